// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP Z80 I/O front end.
// Port decode, command codes and memory geometry.
package vdp_pkg;

    localparam logic [7:0] PORT_DATA     = 8'hBE;
    localparam logic [7:0] PORT_CTRL     = 8'hBF;
    localparam logic [7:0] PORT_DEC_MASK = 8'hC0;

    localparam int NUM_REGS = 11;
    localparam int VRAM_AW  = 14;
    localparam int CRAM_AW  = 5;

    typedef enum logic [1:0] {
        VRAM_RD = 2'd0,
        VRAM_WR = 2'd1,
        REG_WR  = 2'd2,
        CRAM_WR = 2'd3
    } code_t;

    // Only A7:A6 take part in the decode, so the VDP mirrors across 0x80-0xBF.
    function automatic logic port_hit(input logic [7:0] port);
        return (port & PORT_DEC_MASK) == (PORT_DATA & PORT_DEC_MASK);
    endfunction

    function automatic logic port_is_ctrl(input logic [7:0] port);
        return port[0] == PORT_CTRL[0];
    endfunction

endpackage

// File: rtl/vdp_vram.sv
// Single-port 16K x 8 synchronous VRAM.
// Latency: 1 clock read; write on the enable edge. No backpressure.
// Backpressure: none, one access per clock.
module vdp_vram
    import vdp_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [VRAM_AW-1:0] addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata
);

    logic [7:0] mem [0:(1<<VRAM_AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sms_vdp_top.sv
// Z80 I/O front end of the VDP: data/control port protocol, registers, CRAM, VRAM.
// Latency: writes commit on the strobe's leading edge, reads on its trailing edge; rbuf refills 1 clock later.
// Backpressure: none; the Z80 bus is assumed to space accesses at least 4 clocks apart.
module sms_vdp_top
    import vdp_pkg::*;
(
    input  logic        clk,
    input  logic        reset_L,
    inout  wire  [7:0]  data_bus,
    inout  wire  [15:0] addr_bus,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L
);

    localparam logic [3:0] REG_IDX_MAX = 4'(NUM_REGS - 1);

    logic               prev_wr;
    logic               prev_rd;
    logic               rd_armed;
    logic               rd_is_ctrl;
    logic               fill_pend;

    logic [VRAM_AW-1:0] addr;
    code_t              code;
    logic               first_done;
    logic [7:0]         latch;
    logic [7:0]         rbuf;
    logic [7:0]         status;
    logic [7:0]         regs [NUM_REGS];
    logic [7:0]         cram [1<<CRAM_AW];

    logic               wr_act;
    logic               rd_act;
    logic               port_sel;
    logic               port_ctrl;
    logic               wr_commit;
    logic               rd_commit;
    logic [7:0]         wr_data;
    logic [VRAM_AW-1:0] new_addr;
    code_t              new_code;
    logic               prefetch;
    logic               fill_req;
    logic               vram_we;
    logic [VRAM_AW-1:0] vram_addr;
    logic [7:0]         vram_rdata;
    logic               bus_drive;
    logic [7:0]         bus_val;

    assign wr_act    = !IORQ_L && !WR_L;
    assign rd_act    = !IORQ_L && !RD_L;
    assign port_sel  = port_hit(addr_bus[7:0]);
    assign port_ctrl = port_is_ctrl(addr_bus[7:0]);
    assign wr_data   = data_bus;

    assign wr_commit = wr_act && !prev_wr && port_sel;
    assign rd_commit = !rd_act && prev_rd && rd_armed;

    assign new_addr  = {wr_data[5:0], addr[7:0]};
    assign new_code  = code_t'(wr_data[7:6]);
    assign prefetch  = wr_commit && port_ctrl && first_done && (new_code == VRAM_RD);
    assign fill_req  = prefetch || (rd_commit && !rd_is_ctrl);

    assign vram_we   = wr_commit && !port_ctrl && (code != CRAM_WR);
    assign vram_addr = prefetch ? new_addr : addr;

    vdp_vram u_vram (
        .clk   (clk),
        .we    (vram_we),
        .addr  (vram_addr),
        .wdata (wr_data),
        .rdata (vram_rdata)
    );

    // Reset gates the driver so an aborted read releases the bus immediately.
    assign bus_drive = rd_act && port_sel && reset_L;
    assign bus_val   = port_ctrl ? status : rbuf;
    assign data_bus  = bus_drive ? bus_val : 8'hzz;

    // Register and CRAM contents feed the display pipeline, which is not attached yet.
    logic unused_state;
    always_comb begin
        unused_state = ^addr_bus[15:8];
        for (int i = 0; i < NUM_REGS; i++) begin
            unused_state = unused_state ^ (^regs[i]);
        end
        for (int i = 0; i < (1<<CRAM_AW); i++) begin
            unused_state = unused_state ^ (^cram[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            prev_wr    <= 1'b1;
            prev_rd    <= 1'b1;
            rd_armed   <= 1'b0;
            rd_is_ctrl <= 1'b0;
            fill_pend  <= 1'b0;
            addr       <= '0;
            code       <= VRAM_RD;
            first_done <= 1'b0;
            latch      <= '0;
            rbuf       <= '0;
            status     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            for (int i = 0; i < (1<<CRAM_AW); i++) begin
                cram[i] <= '0;
            end
        end else begin
            prev_wr   <= wr_act;
            prev_rd   <= rd_act;
            fill_pend <= fill_req;

            if (fill_pend) begin
                rbuf <= vram_rdata;
            end

            // Arming only on a fresh leading edge keeps a strobe held over reset inert.
            if (rd_act && !prev_rd) begin
                rd_armed   <= port_sel;
                rd_is_ctrl <= port_ctrl;
            end

            if (wr_commit) begin
                if (port_ctrl) begin
                    if (!first_done) begin
                        latch      <= wr_data;
                        addr[7:0]  <= wr_data;
                        first_done <= 1'b1;
                    end else begin
                        code       <= new_code;
                        first_done <= 1'b0;
                        addr       <= (new_code == VRAM_RD) ? new_addr + 14'd1 : new_addr;
                        if (new_code == REG_WR && wr_data[3:0] <= REG_IDX_MAX) begin
                            regs[wr_data[3:0]] <= latch;
                        end
                    end
                end else begin
                    if (code == CRAM_WR) begin
                        cram[addr[CRAM_AW-1:0]] <= wr_data;
                    end
                    rbuf       <= wr_data;
                    addr       <= addr + 14'd1;
                    first_done <= 1'b0;
                end
            end

            if (rd_commit) begin
                rd_armed   <= 1'b0;
                first_done <= 1'b0;
                if (rd_is_ctrl) begin
                    status[7:5] <= 3'b000;
                end else begin
                    addr <= addr + 14'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sms_vdp_top.sv
// Directed bench for sms_vdp_top: Z80 IN/OUT cycles with hand-computed expectations.
module tb_sms_vdp_top;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        IORQ_L = 1'b1;
    logic        RD_L = 1'b1;
    logic        WR_L = 1'b1;
    logic [15:0] tb_addr = 16'h0000;
    logic [7:0]  tb_dat = 8'h00;
    logic        tb_den = 1'b0;
    wire  [7:0]  data_bus;
    wire  [15:0] addr_bus;

    int checks = 0;
    int errors = 0;
    logic [7:0] rv;

    assign addr_bus = tb_addr;
    assign data_bus = tb_den ? tb_dat : 8'hzz;

    // An undriven data bus reads as FF.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data_bus[g]);
    end

    always #5 clk = ~clk;

    sms_vdp_top dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .data_bus (data_bus),
        .addr_bus (addr_bus),
        .IORQ_L   (IORQ_L),
        .RD_L     (RD_L),
        .WR_L     (WR_L)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic out_cycle(input logic [7:0] port, input logic [7:0] val);
        @(negedge clk);
        tb_addr = {8'h00, port};
        tb_dat  = val;
        tb_den  = 1'b1;
        IORQ_L  = 1'b0;
        WR_L    = 1'b0;
        repeat (2) @(negedge clk);
        IORQ_L  = 1'b1;
        WR_L    = 1'b1;
        tb_den  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic in_cycle(input logic [7:0] port, output logic [7:0] val);
        @(negedge clk);
        tb_addr = {8'h00, port};
        IORQ_L  = 1'b0;
        RD_L    = 1'b0;
        @(negedge clk);
        val     = data_bus;
        @(negedge clk);
        IORQ_L  = 1'b1;
        RD_L    = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);

        check("rst_addr",   16'(dut.addr), 16'h0000);
        check("rst_code",   16'(dut.code), 16'h0000);
        check("rst_fd",     16'(dut.first_done), 16'h0000);
        check("rst_latch",  16'(dut.latch), 16'h0000);
        check("rst_rbuf",   16'(dut.rbuf), 16'h0000);
        check("rst_status", 16'(dut.status), 16'h0000);
        check("rst_reg1",   16'(dut.regs[1]), 16'h0000);
        check("rst_cram5",  16'(dut.cram[5]), 16'h0000);
        check("rst_bus_z",  16'(data_bus), 16'h00FF);

        // VRAM write at the top address wraps addr to 0
        out_cycle(8'hBF, 8'hFF);
        check("ctl1_latch", 16'(dut.latch), 16'h00FF);
        check("ctl1_fd",    16'(dut.first_done), 16'h0001);
        out_cycle(8'hBF, 8'h7F);
        out_cycle(8'hBE, 8'h55);
        check("wr_vram3fff", 16'(dut.u_vram.mem[14'h3FFF]), 16'h0055);
        check("wr_addr_wrap", 16'(dut.addr), 16'h0000);
        check("wr_code",    16'(dut.code), 16'h0001);
        check("wr_rbuf",    16'(dut.rbuf), 16'h0055);

        // Prefetch from 3FFF then read it back through the data port
        out_cycle(8'hBF, 8'hFF);
        out_cycle(8'hBF, 8'h3F);
        check("pf_code",  16'(dut.code), 16'h0000);
        check("pf_addr",  16'(dut.addr), 16'h0000);
        check("pf_rbuf",  16'(dut.rbuf), 16'h0055);
        in_cycle(8'hBE, rv);
        check("rd_data",  16'(rv), 16'h0055);
        check("rd_addr",  16'(dut.addr), 16'h0001);

        // Register writes, in range and out of range
        out_cycle(8'hBF, 8'h12);
        out_cycle(8'hBF, 8'h81);
        check("reg1",      16'(dut.regs[1]), 16'h0012);
        check("reg_addr",  16'(dut.addr), 16'h0112);
        check("reg_code",  16'(dut.code), 16'h0002);
        out_cycle(8'hBF, 8'h34);
        out_cycle(8'hBF, 8'h8F);
        check("reg15_r1",  16'(dut.regs[1]), 16'h0012);
        check("reg15_r0",  16'(dut.regs[0]), 16'h0000);
        check("reg15_r10", 16'(dut.regs[10]), 16'h0000);
        check("reg15_addr", 16'(dut.addr), 16'h0F34);

        // CRAM write must leave VRAM at the same address alone
        out_cycle(8'hBF, 8'h05);
        out_cycle(8'hBF, 8'h40);
        out_cycle(8'hBE, 8'h77);
        out_cycle(8'hBF, 8'h05);
        out_cycle(8'hBF, 8'hC0);
        out_cycle(8'hBE, 8'h2A);
        check("cram5",      16'(dut.cram[5]), 16'h002A);
        check("cram_addr",  16'(dut.addr), 16'h0006);
        check("cram_rbuf",  16'(dut.rbuf), 16'h002A);
        check("cram_vram5", 16'(dut.u_vram.mem[14'h0005]), 16'h0077);
        out_cycle(8'hBF, 8'h05);
        out_cycle(8'hBF, 8'h00);
        in_cycle(8'hBE, rv);
        check("vram5_rd",   16'(rv), 16'h0077);
        check("vram5_addr", 16'(dut.addr), 16'h0007);

        // Status read clears the half-written control word
        out_cycle(8'hBF, 8'hAA);
        check("st_fd_set", 16'(dut.first_done), 16'h0001);
        in_cycle(8'hBF, rv);
        check("st_val",    16'(rv), 16'h0000);
        check("st_fd_clr", 16'(dut.first_done), 16'h0000);
        out_cycle(8'hBF, 8'h00);
        out_cycle(8'hBF, 8'h40);
        check("st_addr",   16'(dut.addr), 16'h0000);
        check("st_code",   16'(dut.code), 16'h0001);

        // Foreign ports are ignored
        out_cycle(8'hBE, 8'h11);
        out_cycle(8'h7E, 8'h99);
        out_cycle(8'h00, 8'h99);
        check("ign_addr",  16'(dut.addr), 16'h0001);
        check("ign_fd",    16'(dut.first_done), 16'h0000);
        check("ign_vram0", 16'(dut.u_vram.mem[14'h0000]), 16'h0011);
        check("ign_rbuf",  16'(dut.rbuf), 16'h0011);
        in_cycle(8'h7E, rv);
        check("ign_rd7e",  16'(rv), 16'h00FF);
        in_cycle(8'h00, rv);
        check("ign_rd00",  16'(rv), 16'h00FF);
        check("ign_addr2", 16'(dut.addr), 16'h0001);

        // Reset in the middle of a data read
        @(negedge clk);
        tb_addr = 16'h00BE;
        IORQ_L  = 1'b0;
        RD_L    = 1'b0;
        @(negedge clk);
        check("mid_bus_drv", 16'(data_bus), 16'h0011);
        reset_L = 1'b0;
        #1;
        check("mid_bus_rel", 16'(data_bus), 16'h00FF);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        repeat (2) @(negedge clk);
        IORQ_L  = 1'b1;
        RD_L    = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_addr", 16'(dut.addr), 16'h0000);
        check("mid_rbuf", 16'(dut.rbuf), 16'h0000);

        // Write strobe held across reset release
        reset_L = 1'b0;
        @(negedge clk);
        tb_addr = 16'h00BF;
        tb_dat  = 8'hAA;
        tb_den  = 1'b1;
        IORQ_L  = 1'b0;
        WR_L    = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        IORQ_L  = 1'b1;
        WR_L    = 1'b1;
        tb_den  = 1'b0;
        repeat (3) @(negedge clk);
        check("held_fd",    16'(dut.first_done), 16'h0000);
        check("held_latch", 16'(dut.latch), 16'h0000);
        out_cycle(8'hBF, 8'hAA);
        check("post_fd",    16'(dut.first_done), 16'h0001);
        check("post_latch", 16'(dut.latch), 16'h00AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
